// File: rtl/spi_reg_read_if.sv
// Bus interface for the SPI register reader.
// Carries the request/response handshake and the SPI lines of the read path.
interface spi_reg_read_if #(
    parameter int NUM_BYTES = 1
);
    logic                   enable;
    logic [5:0]             address;
    logic [8*NUM_BYTES-1:0] readData;
    logic                   readComplete;
    logic                   MOSI;
    logic                   MISO;
    logic                   SCLK;

    // Requester side: issues reads, drives the externally generated SCLK and slave MISO.
    modport master (
        output enable, address, MISO, SCLK,
        input  readData, readComplete, MOSI
    );

    // Reader side: the spi_reg_read block itself.
    modport slave (
        input  enable, address, MISO, SCLK,
        output readData, readComplete, MOSI
    );
endinterface

// File: rtl/spi_reg_read.sv
// SPI register reader (mode 3, SCLK generated externally and oversampled on clk).
// Sends {R=1, MB, address} on MOSI, then collects NUM_BYTES bytes from MISO, MSB first.
module spi_reg_read #(
    parameter int NUM_BYTES = 1
) (
    input  logic         clk,
    input  logic         reset,
    spi_reg_read_if.slave bus
);
    localparam int         RX_BITS = 8 * NUM_BYTES;
    localparam logic [5:0] RX_LAST = 6'(RX_BITS - 1);
    localparam logic       MB      = (NUM_BYTES > 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RX,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               sclk_s1;
    logic               sclk_s2;
    logic               sclk_d;
    logic               rise;
    logic               fall;
    logic [7:0]         cmd;
    logic [3:0]         bit_cnt;
    logic [5:0]         rx_cnt;
    logic [RX_BITS-1:0] rx_shift;

    // Synchronise SCLK into the clk domain; flops rest at the SCLK idle level (high)
    // so that leaving reset never manufactures a spurious rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
        end else begin
            sclk_s1 <= bus.SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
        end
    end

    assign rise = sclk_s2 & ~sclk_d;
    assign fall = ~sclk_s2 & sclk_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived outputs; dropping enable aborts any frame.
    always_comb begin
        next_state       = state;
        bus.MOSI         = 1'b0;
        bus.readComplete = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    next_state = CMD;
                end
            end
            CMD: begin
                bus.MOSI = cmd[7];
                if (!bus.enable) begin
                    next_state = IDLE;
                end else if (rise && bit_cnt == 4'd7) begin
                    next_state = RX;
                end
            end
            RX: begin
                if (!bus.enable) begin
                    next_state = IDLE;
                end else if (rise && rx_cnt == RX_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.readComplete = 1'b1;
                if (!bus.enable) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command shifter, bit counters and receive shifter; readData only updates on a full frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd          <= '0;
            bit_cnt      <= '0;
            rx_cnt       <= '0;
            rx_shift     <= '0;
            bus.readData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        cmd      <= {1'b1, MB, bus.address};
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end
                end
                CMD: begin
                    if (bus.enable) begin
                        if (rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_cnt <= '0;
                            end
                        end else if (fall && bit_cnt != 4'd0) begin
                            cmd <= {cmd[6:0], 1'b0};
                        end
                    end
                end
                RX: begin
                    if (bus.enable && rise) begin
                        rx_shift <= {rx_shift[RX_BITS-2:0], bus.MISO};
                        rx_cnt   <= rx_cnt + 6'd1;
                        if (rx_cnt == RX_LAST) begin
                            bus.readData <= {rx_shift[RX_BITS-2:0], bus.MISO};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_read.sv
// Testbench for spi_reg_read: a 1-byte and a 6-byte reader share SCLK/MISO/address,
// each with its own enable, checked against a frame-level reference model.
module tb_spi_reg_read;
    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       miso;
    logic       en1;
    logic       en6;
    logic [5:0] addr;

    int pass_count  = 0;
    int check_count = 0;

    logic [7:0]  exp_data1;
    logic [47:0] exp_data6;

    always #5 clk = ~clk;

    spi_reg_read_if #(.NUM_BYTES(1)) bus1();
    spi_reg_read_if #(.NUM_BYTES(6)) bus6();

    assign bus1.enable  = en1;
    assign bus1.address = addr;
    assign bus1.SCLK    = sclk;
    assign bus1.MISO    = miso;
    assign bus6.enable  = en6;
    assign bus6.address = addr;
    assign bus6.SCLK    = sclk;
    assign bus6.MISO    = miso;

    spi_reg_read #(.NUM_BYTES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    spi_reg_read #(.NUM_BYTES(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));

    // Reference command byte: read flag, multi-byte flag, then address.
    function automatic logic [7:0] model_cmd(input int nb, input logic [5:0] a);
        logic mb;
        mb = (nb > 1);
        return {1'b1, mb, a};
    endfunction

    // Act as master and slave: generate SCLK, record MOSI before each rise, shift payload
    // onto MISO after each fall. Stops after max_rises rising edges, leaving SCLK high.
    task automatic drive_frame(input int nb, input logic [5:0] a, input logic [47:0] payload,
                               input int phase, input int max_rises, output logic [7:0] mosi_seen);
        int total;
        int n;
        total     = 8 + 8 * nb;
        n         = (max_rises < total) ? max_rises : total;
        mosi_seen = '0;
        addr      = a;
        @(negedge clk);
        if (nb == 1) en1 = 1'b1;
        else         en6 = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            sclk = 1'b0;
            if (k >= 8) miso = payload[8*nb-1-(k-8)];
            repeat (phase) @(negedge clk);
            if (k < 8) mosi_seen[7-k] = (nb == 1) ? bus1.MOSI : bus6.MOSI;
            sclk = 1'b1;
            if (k != n - 1) repeat (phase) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en1   = 1'b0;
        en6   = 1'b0;
        sclk  = 1'b1;
        miso  = 1'b0;
        addr  = '0;
        #1;
        check_count++;
        if (bus1.readData !== 8'h00) $display("[TB] FAIL reset_data1: got %0h expected 0", bus1.readData);
        else pass_count++;
        check_count++;
        if (bus6.readData !== 48'h0) $display("[TB] FAIL reset_data6: got %0h expected 0", bus6.readData);
        else pass_count++;
        check_count++;
        if (bus1.readComplete !== 1'b0 || bus6.readComplete !== 1'b0)
            $display("[TB] FAIL reset_complete: got %b%b expected 00", bus1.readComplete, bus6.readComplete);
        else pass_count++;
        check_count++;
        if (bus1.MOSI !== 1'b0 || bus6.MOSI !== 1'b0)
            $display("[TB] FAIL reset_mosi: got %b%b expected 00", bus1.MOSI, bus6.MOSI);
        else pass_count++;
        exp_data1 = '0;
        exp_data6 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One complete 1-byte read, including the exact readComplete latency.
    task automatic run_single(input logic [5:0] a, input logic [7:0] data, input int phase);
        logic [7:0] seen;
        drive_frame(1, a, {40'h0, data}, phase, 100, seen);
        exp_data1 = data;
        repeat (2) @(negedge clk);
        check_count++;
        if (bus1.readComplete !== 1'b0) $display("[TB] FAIL single_latency_early: got %b expected 0", bus1.readComplete);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if (bus1.readComplete !== 1'b1) $display("[TB] FAIL single_latency: got %b expected 1", bus1.readComplete);
        else pass_count++;
        check_count++;
        if (seen !== model_cmd(1, a)) $display("[TB] FAIL single_cmd: got %0h expected %0h", seen, model_cmd(1, a));
        else pass_count++;
        check_count++;
        if (bus1.readData !== exp_data1) $display("[TB] FAIL single_data: got %0h expected %0h", bus1.readData, exp_data1);
        else pass_count++;
        en1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        run_single(6'h32, 8'hA5, 4);
    endtask

    task automatic test_random_single();
        for (int i = 0; i < 3; i++) begin
            run_single(6'($urandom), 8'($urandom), int'($urandom_range(3, 6)));
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] seen;
        logic [7:0] c;
        c = model_cmd(1, 6'h32);
        drive_frame(1, 6'h32, 48'h0, 4, 3, seen);
        repeat (4) @(negedge clk);
        check_count++;
        if (bus1.MOSI !== c[5]) $display("[TB] FAIL midcmd_mosi: got %b expected %b", bus1.MOSI, c[5]);
        else pass_count++;
        #2;
        reset = 1'b0;
        #1;
        check_count++;
        if (bus1.MOSI !== 1'b0) $display("[TB] FAIL async_mosi: got %b expected 0", bus1.MOSI);
        else pass_count++;
        check_count++;
        if (bus1.readData !== 8'h00 || bus6.readData !== 48'h0)
            $display("[TB] FAIL async_data: got %0h/%0h expected 0/0", bus1.readData, bus6.readData);
        else pass_count++;
        exp_data1 = '0;
        exp_data6 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            check_count++;
            if (bus1.MOSI !== 1'b0 || bus1.readComplete !== 1'b0)
                $display("[TB] FAIL reset_hold: got mosi=%b complete=%b expected 0/0", bus1.MOSI, bus1.readComplete);
            else pass_count++;
        end
        en1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_count++;
        if (bus1.MOSI !== 1'b0 || bus1.readComplete !== 1'b0 || bus1.readData !== exp_data1)
            $display("[TB] FAIL after_reset_idle: got mosi=%b complete=%b data=%0h expected 0/0/0",
                     bus1.MOSI, bus1.readComplete, bus1.readData);
        else pass_count++;
    endtask

    task automatic run_multi(input logic [5:0] a, input logic [47:0] payload, input int phase);
        logic [7:0] seen;
        drive_frame(6, a, payload, phase, 100, seen);
        exp_data6 = payload;
        repeat (3) @(negedge clk);
        check_count++;
        if (bus6.readComplete !== 1'b1) $display("[TB] FAIL multi_complete: got %b expected 1", bus6.readComplete);
        else pass_count++;
        check_count++;
        if (seen !== model_cmd(6, a)) $display("[TB] FAIL multi_cmd: got %0h expected %0h", seen, model_cmd(6, a));
        else pass_count++;
        check_count++;
        if (bus6.readData !== exp_data6) $display("[TB] FAIL multi_data: got %0h expected %0h", bus6.readData, exp_data6);
        else pass_count++;
        check_count++;
        if (bus1.readData !== exp_data1) $display("[TB] FAIL multi_other_data: got %0h expected %0h", bus1.readData, exp_data1);
        else pass_count++;
        en6 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_multi_byte();
        run_multi(6'h32, 48'h010203040506, 4);
        for (int i = 0; i < 2; i++) begin
            run_multi(6'($urandom), {16'($urandom), 32'($urandom)}, int'($urandom_range(3, 5)));
        end
    endtask

    task automatic test_abort();
        logic [7:0] seen;
        logic [7:0] c;
        // Abort during the receive phase of a 1-byte read.
        drive_frame(1, 6'($urandom), 48'($urandom), 4, 12, seen);
        repeat (4) @(negedge clk);
        en1 = 1'b0;
        @(negedge clk);
        check_count++;
        if (bus1.readData !== exp_data1) $display("[TB] FAIL abort_rx_data: got %0h expected %0h", bus1.readData, exp_data1);
        else pass_count++;
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            check_count++;
            if (bus1.readComplete !== 1'b0) $display("[TB] FAIL abort_rx_complete: got %b expected 0", bus1.readComplete);
            else pass_count++;
        end
        check_count++;
        if (bus1.readData !== exp_data1) $display("[TB] FAIL abort_rx_hold: got %0h expected %0h", bus1.readData, exp_data1);
        else pass_count++;
        // Abort during the command phase of a 6-byte read while MOSI is high.
        c = model_cmd(6, 6'h32);
        drive_frame(6, 6'h32, 48'h0, 4, 3, seen);
        repeat (4) @(negedge clk);
        check_count++;
        if (bus6.MOSI !== c[5]) $display("[TB] FAIL abort_cmd_pre: got %b expected %b", bus6.MOSI, c[5]);
        else pass_count++;
        en6 = 1'b0;
        @(negedge clk);
        check_count++;
        if (bus6.MOSI !== 1'b0) $display("[TB] FAIL abort_cmd_idle: got %b expected 0", bus6.MOSI);
        else pass_count++;
        check_count++;
        if (bus6.readData !== exp_data6 || bus6.readComplete !== 1'b0)
            $display("[TB] FAIL abort_cmd_data: got %0h/%b expected %0h/0", bus6.readData, bus6.readComplete, exp_data6);
        else pass_count++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_enable();
        logic [7:0] seen;
        logic [7:0] data;
        data = 8'($urandom);
        drive_frame(1, 6'($urandom), {40'h0, data}, 4, 100, seen);
        exp_data1 = data;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            check_count++;
            if (bus1.readComplete !== 1'b1 || bus1.MOSI !== 1'b0)
                $display("[TB] FAIL hold_done: got complete=%b mosi=%b expected 1/0", bus1.readComplete, bus1.MOSI);
            else pass_count++;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        check_count++;
        if (bus1.readData !== exp_data1) $display("[TB] FAIL hold_data: got %0h expected %0h", bus1.readData, exp_data1);
        else pass_count++;
        en1 = 1'b0;
        @(negedge clk);
        check_count++;
        if (bus1.readComplete !== 1'b0) $display("[TB] FAIL hold_release: got %b expected 0", bus1.readComplete);
        else pass_count++;
        repeat (2) @(negedge clk);
        run_single(6'($urandom), 8'($urandom), 4);
    endtask

    task automatic test_glitch_phase3();
        sclk = 1'b0;
        @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        check_count++;
        if (bus1.MOSI !== 1'b0 || bus1.readComplete !== 1'b0 || bus1.readData !== exp_data1)
            $display("[TB] FAIL glitch_idle: got mosi=%b complete=%b data=%0h expected 0/0/%0h",
                     bus1.MOSI, bus1.readComplete, bus1.readData, exp_data1);
        else pass_count++;
        run_single(6'($urandom), 8'($urandom), 3);
        run_multi(6'($urandom), {16'($urandom), 32'($urandom)}, 3);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_async_reset();
        test_random_single();
        test_multi_byte();
        test_single_byte();
        test_abort();
        test_hold_enable();
        test_glitch_phase3();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
